// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops plus iterative shift-add
// multiply and restoring divide, with a registered result and a one-cycle done pulse.
module alu_mc #(
    parameter int SIZE = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [3:0]          command,
    input  logic [SIZE-1:0]     a,
    input  logic [SIZE-1:0]     b,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [2*SIZE-1:0]   result
);

    localparam int SH = $clog2(SIZE);
    localparam int CW = $clog2(SIZE + 1);

    localparam logic [3:0] CMD_ADD = 4'd0;
    localparam logic [3:0] CMD_SUB = 4'd1;
    localparam logic [3:0] CMD_AND = 4'd2;
    localparam logic [3:0] CMD_OR  = 4'd3;
    localparam logic [3:0] CMD_XOR = 4'd4;
    localparam logic [3:0] CMD_NOT = 4'd5;
    localparam logic [3:0] CMD_SHL = 4'd6;
    localparam logic [3:0] CMD_SHR = 4'd7;
    localparam logic [3:0] CMD_SRA = 4'd8;
    localparam logic [3:0] CMD_SLT = 4'd9;
    localparam logic [3:0] CMD_MUL = 4'd10;
    localparam logic [3:0] CMD_DIV = 4'd11;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t              state, next_state;
    logic [3:0]          op_cmd;
    logic [SIZE-1:0]     op_a, op_b;
    logic [2*SIZE-1:0]   p;
    logic [CW-1:0]       cnt;
    logic                accept, last_iter;
    logic [SIZE:0]       add_sum, sub_diff, mul_sum, div_shift, div_diff;
    logic                div_qbit;
    logic [SIZE-1:0]     div_rem;
    logic [2*SIZE-1:0]   wb_result;
    logic                wb_ovf;

    assign busy      = (state != IDLE);
    assign accept    = enable && (state == IDLE) && !done;
    assign last_iter = (cnt == CW'(SIZE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // DONE is the write-back cycle; divide by zero skips the iterative path
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (command == CMD_MUL)                      next_state = MUL;
                    else if (command == CMD_DIV && b != '0)      next_state = DIV;
                    else                                         next_state = DONE;
                end
            end
            MUL, DIV: if (last_iter) next_state = DONE;
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    assign add_sum  = {1'b0, op_a} + {1'b0, op_b};
    assign sub_diff = {1'b0, op_a} - {1'b0, op_b};

    // p holds {partial product, remaining multiplier bits} during MUL
    assign mul_sum   = {1'b0, p[2*SIZE-1:SIZE]} + (p[0] ? {1'b0, op_a} : '0);

    // p holds {remainder, dividend/quotient bits} during DIV
    assign div_shift = p[2*SIZE-1:SIZE-1];
    assign div_diff  = div_shift - {1'b0, op_b};
    assign div_qbit  = ~div_diff[SIZE];
    assign div_rem   = div_qbit ? div_diff[SIZE-1:0] : div_shift[SIZE-1:0];

    always_comb begin
        wb_result = '0;
        wb_ovf    = 1'b0;
        case (op_cmd)
            CMD_ADD: begin
                wb_result = {{(SIZE-1){1'b0}}, add_sum};
                wb_ovf    = (op_a[SIZE-1] == op_b[SIZE-1]) && (add_sum[SIZE-1] != op_a[SIZE-1]);
            end
            CMD_SUB: begin
                wb_result = {{(SIZE-1){1'b0}}, sub_diff};
                wb_ovf    = (op_a[SIZE-1] != op_b[SIZE-1]) && (sub_diff[SIZE-1] != op_a[SIZE-1]);
            end
            CMD_AND: wb_result = {{SIZE{1'b0}}, op_a & op_b};
            CMD_OR:  wb_result = {{SIZE{1'b0}}, op_a | op_b};
            CMD_XOR: wb_result = {{SIZE{1'b0}}, op_a ^ op_b};
            CMD_NOT: wb_result = {{SIZE{1'b0}}, ~op_a};
            CMD_SHL: wb_result = {{SIZE{1'b0}}, op_a << op_b[SH-1:0]};
            CMD_SHR: wb_result = {{SIZE{1'b0}}, op_a >> op_b[SH-1:0]};
            CMD_SRA: wb_result = {{SIZE{1'b0}}, $signed(op_a) >>> op_b[SH-1:0]};
            CMD_SLT: wb_result = {{(2*SIZE-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            CMD_MUL: wb_result = p;
            CMD_DIV: begin
                if (op_b == '0) begin
                    wb_result = {op_a, {SIZE{1'b1}}};
                    wb_ovf    = 1'b1;
                end else begin
                    wb_result = p;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_cmd   <= '0;
            op_a     <= '0;
            op_b     <= '0;
            p        <= '0;
            cnt      <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
            result   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_cmd <= command;
                        op_a   <= a;
                        op_b   <= b;
                        cnt    <= '0;
                        p      <= (command == CMD_DIV) ? {{SIZE{1'b0}}, a} : {{SIZE{1'b0}}, b};
                    end
                end
                MUL: begin
                    p   <= {mul_sum, p[SIZE-1:1]};
                    cnt <= cnt + CW'(1);
                end
                DIV: begin
                    p   <= {div_rem, p[SIZE-2:0], div_qbit};
                    cnt <= cnt + CW'(1);
                end
                DONE: begin
                    result   <= wb_result;
                    overflow <= wb_ovf;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc at SIZE=4: directed vectors issued back-to-back with
// enable held high, a negedge monitor checking busy/done timing and results.
module tb_alu_mc;

    localparam int SIZE = 4;

    logic               clk;
    logic               rst;
    logic               enable;
    logic [3:0]         command;
    logic [SIZE-1:0]    a;
    logic [SIZE-1:0]    b;
    logic               busy;
    logic               done;
    logic               overflow;
    logic [2*SIZE-1:0]  result;

    typedef struct {
        logic [7:0] res;
        logic       ovf;
        int         due;
    } exp_t;

    typedef struct {
        logic [3:0] cmd;
        logic [3:0] x;
        logic [3:0] y;
        logic [7:0] res;
        logic       ovf;
        int         lat;
    } vec_t;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    alu_mc #(.SIZE(SIZE)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .command  (command),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .result   (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Accept edge is assumed to be the next posedge; later edges see scrambled inputs
    task automatic applyStimulus(input logic [3:0] cmd, input logic [3:0] x, input logic [3:0] y,
                                 input logic [7:0] res, input logic ovf, input int lat,
                                 input bit at_neg);
        exp_t e;
        if (!at_neg) @(negedge clk);
        enable  = 1'b1;
        command = cmd;
        a       = x;
        b       = y;
        @(posedge clk);
        #1;
        e.res = res;
        e.ovf = ovf;
        e.due = cyc + lat;
        sb.push_back(e);
        command = 4'($urandom);
        a       = 4'($urandom);
        b       = 4'($urandom);
        repeat (lat + 1) @(posedge clk);
        #1;
    endtask

    // Busy is expected for every cycle an entry is outstanding; done only at its due cycle
    always @(negedge clk) begin
        if (sb.size() > 0 && cyc >= sb[0].due) begin
            checkOutput("done_pulse", {14'd0, busy, done}, 16'h0001);
            checkOutput("result", {8'd0, result}, {8'd0, sb[0].res});
            checkOutput("overflow", {15'd0, overflow}, {15'd0, sb[0].ovf});
            void'(sb.pop_front());
        end else begin
            checkOutput("busy_done", {14'd0, busy, done}, {14'd0, (sb.size() > 0), 1'b0});
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    vec_t vecs[$];

    initial begin
        vecs = '{
            '{4'd0,  4'h7, 4'h1, 8'h08, 1'b1, 1},
            '{4'd10, 4'hF, 4'hF, 8'hE1, 1'b0, 5},
            '{4'd11, 4'hD, 4'h4, 8'h13, 1'b0, 5},
            '{4'd11, 4'h5, 4'h0, 8'h5F, 1'b1, 1},
            '{4'd1,  4'h0, 4'h1, 8'h1F, 1'b0, 1},
            '{4'd8,  4'h8, 4'h1, 8'h0C, 1'b0, 1},
            '{4'd0,  4'h8, 4'h8, 8'h10, 1'b1, 1},
            '{4'd1,  4'h8, 4'h1, 8'h07, 1'b1, 1},
            '{4'd2,  4'hC, 4'hA, 8'h08, 1'b0, 1},
            '{4'd3,  4'hC, 4'hA, 8'h0E, 1'b0, 1},
            '{4'd4,  4'hC, 4'hA, 8'h06, 1'b0, 1},
            '{4'd5,  4'h5, 4'h0, 8'h0A, 1'b0, 1},
            '{4'd6,  4'h3, 4'h6, 8'h0C, 1'b0, 1},
            '{4'd7,  4'hC, 4'h1, 8'h06, 1'b0, 1},
            '{4'd9,  4'h8, 4'h1, 8'h01, 1'b0, 1},
            '{4'd9,  4'h3, 4'h2, 8'h00, 1'b0, 1},
            '{4'd13, 4'hF, 4'hF, 8'h00, 1'b0, 1},
            '{4'd10, 4'h3, 4'h5, 8'h0F, 1'b0, 5},
            '{4'd11, 4'hF, 4'h1, 8'h0F, 1'b0, 5},
            '{4'd11, 4'h7, 4'h9, 8'h70, 1'b0, 5}
        };

        rst     = 1'b1;
        enable  = 1'b0;
        command = 4'd0;
        a       = '0;
        b       = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_result", {8'd0, result}, 16'h0000);
        checkOutput("reset_flags", {13'd0, busy, done, overflow}, 16'h0000);

        // First request is presented on the same negedge that releases reset
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].cmd, vecs[i].x, vecs[i].y, vecs[i].res, vecs[i].ovf,
                          vecs[i].lat, (i == 0));
        end

        // Abort a multiply two edges after acceptance; no completion may follow
        begin
            exp_t e;
            @(negedge clk);
            enable  = 1'b1;
            command = 4'd10;
            a       = 4'hF;
            b       = 4'hF;
            @(posedge clk);
            #1;
            e.res = 8'hE1;
            e.ovf = 1'b0;
            e.due = cyc + 5;
            sb.push_back(e);
            command = 4'($urandom);
            a       = 4'($urandom);
            b       = 4'($urandom);
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b1;
            sb.delete();
            #1;
            checkOutput("abort_result", {8'd0, result}, 16'h0000);
            checkOutput("abort_flags", {13'd0, busy, done, overflow}, 16'h0000);
            @(negedge clk);
            rst = 1'b0;
            applyStimulus(4'd0, 4'h3, 4'h2, 8'h05, 1'b0, 1, 1'b1);
        end

        enable = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 16'(sb.size()), 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
